// File: rtl/adder_cs_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder/subtractor.
package adder_cs_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_BLOCK = 4;
    localparam int DEF_SPS   = 2;

    function automatic int nseg(input int width, input int block);
        return width / block;
    endfunction

    // One cycle for the dual-carry precompute plus one per resolve stage.
    localparam int DEF_LATENCY = 1 + nseg(DEF_WIDTH, DEF_BLOCK) / DEF_SPS;

endpackage

// File: rtl/adder_cs_pipe_if.sv
// Operand/result stream bundle; the adder is the slave, its driver/consumer the master.
interface adder_cs_pipe_if
    import adder_cs_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] outSum;
    logic             Cout;
    logic             Overflow;

    modport slave (
        input  in_valid, inA, inB, Cin, sub, out_ready,
        output in_ready, out_valid, outSum, Cout, Overflow
    );

    modport master (
        output in_valid, inA, inB, Cin, sub, out_ready,
        input  in_ready, out_valid, outSum, Cout, Overflow
    );
endinterface

// File: rtl/adder_cs_segment.sv
// One BLOCK-bit segment: sum and carry-out for both possible carry-ins.
module adder_cs_segment
    import adder_cs_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0]   a,
    input  logic [BLOCK-1:0]   b,
    output logic [2*BLOCK+1:0] pair
);
    typedef struct packed {
        logic [BLOCK-1:0] sum0;
        logic [BLOCK-1:0] sum1;
        logic             c0;
        logic             c1;
    } seg_pair_t;

    seg_pair_t p;

    always_comb begin
        p = '0;
        {p.c0, p.sum0} = {1'b0, a} + {1'b0, b};
        {p.c1, p.sum1} = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};
    end

    assign pair = p;

endmodule

// File: rtl/adder_cs_pipe.sv
// Pipelined carry-select add/sub: dual-carry segment precompute, then SEGS_PER_STAGE
// segments resolved per stage, with a collapsing valid/ready pipeline.
module adder_cs_pipe
    import adder_cs_pkg::*;
#(
    parameter int WIDTH          = DEF_WIDTH,
    parameter int BLOCK          = DEF_BLOCK,
    parameter int SEGS_PER_STAGE = DEF_SPS
) (
    input  logic           clk,
    input  logic           rst,
    adder_cs_pipe_if.slave bus
);
    localparam int NSEG = nseg(WIDTH, BLOCK);
    localparam int SPS  = SEGS_PER_STAGE;
    localparam int R    = NSEG / SPS;
    localparam int GW   = SPS * BLOCK;

    typedef struct packed {
        logic [BLOCK-1:0] sum0;
        logic [BLOCK-1:0] sum1;
        logic             c0;
        logic             c1;
    } seg_pair_t;

    logic [WIDTH-1:0]      b_eff;
    logic                  c_eff;
    seg_pair_t [NSEG-1:0]  pair_c;
    logic [1:0]            cm_c;

    logic [R:0]            vld_pipe;
    logic [R:0]            acc;
    logic [R:0]            ld;
    logic [R:0]            cy_q;
    logic [R-1:0][1:0]     cm_q;
    logic                  ovf_q;
    logic [R-1:0]          grp_cout;
    logic                  c_top;
    logic [WIDTH-1:0]      sum_out;

    assign b_eff = bus.sub ? ~bus.inB : bus.inB;
    assign c_eff = bus.sub ? ~bus.Cin : bus.Cin;

    for (genvar s = 0; s < NSEG; s++) begin : g_seg
        adder_cs_segment #(.BLOCK(BLOCK)) u_seg (
            .a    (bus.inA[s*BLOCK +: BLOCK]),
            .b    (b_eff[s*BLOCK +: BLOCK]),
            .pair (pair_c[s])
        );
    end

    // Carry into the top sum bit: [1] if the top segment sees carry-in 1, [0] otherwise.
    assign cm_c = {pair_c[NSEG-1].sum1[BLOCK-1], pair_c[NSEG-1].sum0[BLOCK-1]}
                ^ {2{bus.inA[WIDTH-1] ^ b_eff[WIDTH-1]}};

    // acc[k]: stage k may load this cycle; ld[k]: stage k actually loads.
    always_comb begin : p_hs
        logic a;
        acc = '0;
        ld  = '0;
        a   = !vld_pipe[R] || bus.out_ready;
        acc[R] = a;
        for (int k = R - 1; k >= 0; k--) begin
            ld[k+1] = vld_pipe[k] && a;
            a       = !vld_pipe[k] || a;
            acc[k]  = a;
        end
        ld[0] = bus.in_valid && a;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            cy_q     <= '0;
            cm_q     <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (acc[0]) vld_pipe[0] <= bus.in_valid;
            for (int k = 1; k <= R; k++)
                if (acc[k]) vld_pipe[k] <= vld_pipe[k-1];
            if (ld[0]) begin
                cy_q[0] <= c_eff;
                cm_q[0] <= cm_c;
            end
            for (int k = 1; k <= R; k++)
                if (ld[k]) cy_q[k] <= grp_cout[k-1];
            for (int k = 1; k < R; k++)
                if (ld[k]) cm_q[k] <= cm_q[k-1];
            if (ld[R]) ovf_q <= cm_q[R-1][c_top] ^ grp_cout[R-1];
        end
    end

    // Group g is carried as segment pairs through stages 0..g, resolved into stage g+1,
    // then carried as plain sum bits through stage R.
    for (genvar g = 0; g < R; g++) begin : g_grp
        seg_pair_t [SPS-1:0] pq [g+1];
        logic [GW-1:0]       sq [R-g];
        logic [GW-1:0]       sel;
        logic                cout_g;

        always_comb begin : p_sel
            logic c;
            sel = '0;
            c   = cy_q[g];
            for (int j = 0; j < SPS; j++) begin
                sel[j*BLOCK +: BLOCK] = c ? pq[g][j].sum1 : pq[g][j].sum0;
                c = c ? pq[g][j].c1 : pq[g][j].c0;
            end
            cout_g = c;
        end

        assign grp_cout[g] = cout_g;

        if (g == R - 1) begin : g_top
            logic ct;
            always_comb begin
                ct = cy_q[g];
                for (int j = 0; j < SPS - 1; j++)
                    ct = ct ? pq[g][j].c1 : pq[g][j].c0;
            end
            assign c_top = ct;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i <= g; i++)  pq[i] <= '0;
                for (int i = 0; i < R - g; i++) sq[i] <= '0;
            end else begin
                if (ld[0]) pq[0] <= pair_c[g*SPS +: SPS];
                for (int i = 1; i <= g; i++)
                    if (ld[i]) pq[i] <= pq[i-1];
                if (ld[g+1]) sq[0] <= sel;
                for (int i = 1; i < R - g; i++)
                    if (ld[g+1+i]) sq[i] <= sq[i-1];
            end
        end

        assign sum_out[g*GW +: GW] = sq[R-g-1];
    end

    assign bus.in_ready  = acc[0];
    assign bus.out_valid = vld_pipe[R];
    assign bus.outSum    = sum_out;
    assign bus.Cout      = cy_q[R];
    assign bus.Overflow  = ovf_q;

endmodule
